uart_txrx_top: RTL and testbench
================================

# uart_txrx_top

Full-duplex 8N1 UART block: a transmitter serialises a byte on `tx` when `tx_start` is pulsed, and an independent receiver deserialises frames arriving on `rx` and pulses `rx_ready`. It is the serial front end between a byte-wide host interface and the pins. Tying `tx` to `rx` (loopback) must return every transmitted byte unchanged.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT` is derived as CLK_FREQ/BAUD using integer division; the default is 434. It must be ≥ 4.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `rx`  in  1  serial input; asynchronous to `clk`.
- `tx_data`  in  8  byte to send; sampled on the cycle `tx_start` is accepted.
- `tx_start`  in  1  transmit request, level-sampled.
- `tx`  out  1  serial output.
- `rx_data`  out  8  last correctly received byte.
- `rx_ready`  out  1  one-cycle pulse when `rx_data` is updated.
- `tx_busy`  out  1  high while a frame is being transmitted.

## Operation
- **Frame format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Line idles high.

**TX FSM: IDLE → START → DATA → STOP → IDLE**
- IDLE: `tx`=1, `tx_busy`=0. If `tx_start`=1, latch `tx_data` into a shift register and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: each bit is driven for CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then return to IDLE.
- `tx_start` is ignored outside IDLE; there is no queueing.
- `tx_data` changes after acceptance do not affect the frame in flight.

**RX FSM: IDLE → START → DATA → STOP → IDLE**
- `rx` passes through a 2-flop synchroniser, which resets to 1.
- IDLE: wait for the synchronised `rx` to be 0.
- START: count CLKS_PER_BIT/2 cycles and re-check. If `rx` is still 0, proceed to DATA; if not, treat it as a glitch and return to IDLE.
- DATA: sample 8 bits, each CLKS_PER_BIT cycles apart (mid-bit), shifting LSB first.
- STOP: sample once more after CLKS_PER_BIT cycles.
  - Sample = 1: load `rx_data` and pulse `rx_ready` for exactly one cycle.
  - Sample = 0 (framing error): discard the byte. `rx_data` is unchanged and there is no pulse.
- After STOP the receiver returns to IDLE immediately, so back-to-back frames are accepted.
- `rx_data` holds its value until the next good frame.
- TX and RX are fully independent and may run simultaneously.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `rx_data`=8'h00, `rx_ready`=0. Both FSMs are in IDLE with all counters cleared.
- Reset mid-frame aborts immediately. `tx` returns high asynchronously and any partial RX byte is dropped.
- TX latency: `tx_start` is sampled at edge N. At edge N+1, `tx` falls and `tx_busy` rises.
- The full frame spans exactly 10×CLKS_PER_BIT cycles.
- `tx_busy` falls in the cycle the FSM re-enters IDLE. A `tx_start` asserted in that same cycle starts the next frame with no gap.
- RX latency: `rx_ready` pulses 2 cycles (synchroniser) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT + 1 cycles after the falling edge of the start bit.
- In loopback at the defaults, `rx_ready` pulses about 4.1k cycles after `tx_start`, before `tx_busy` falls.

## Configuration
- **Macro:** `UART_FRAME_ERR_EN`.
- **When defined:** adds output `rx_frame_err` (1 bit, reset 0). It pulses for one cycle in place of `rx_ready` when the stop bit samples 0.
- **When undefined:** the port does not exist and bad frames are dropped silently.
- Behaviour is otherwise identical in both builds.

## Structure
- **Package `uart_pkg`:**
  - TX and RX state encodings (IDLE, START, DATA, STOP).
  - Frame constants: DATA_BITS = 8, STOP_BITS = 1.
  - A function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- **Sub-module `uart_rx`:** holds the synchroniser, RX FSM, rx_data and rx_ready.
- **Inline in the top:** the transmitter FSM.

## Test plan
- Reset low for 8 cycles then release → `tx`=1, `rx_ready`=0, `rx_data`=00 throughout reset.
- Loopback: `tx_data`=8'h41 with a 1-cycle `tx_start` → `tx` low 1 cycle later.
  - Line sequence is 0,1,0,0,0,0,0,1,0,1, each bit 434 cycles.
  - `rx_ready` pulses once and `rx_data`=8'h41.
- Loopback back-to-back 8'h00 then 8'hFF, with the second `tx_start` held during the first frame → exactly two frames, two `rx_ready` pulses, values 00 then FF.
- External `rx` low glitch of 100 cycles → no `rx_ready` and the receiver returns to IDLE.
- External frame 8'hA5 with the stop bit forced 0 → no `rx_ready`, `rx_data` unchanged; with `UART_FRAME_ERR_EN`, `rx_frame_err` pulses once.
- Reset asserted mid-TX (during data bit 3) → `tx`=1 immediately and `tx_busy`=0. After release, a new 8'h41 frame is transmitted and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, 8N1 frame constants, bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_txrx_top_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, registered rx_data/rx_ready.
// rx_ready rises 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge; UART_FRAME_ERR_EN adds rx_frame_err_o.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_ready_o
`ifdef UART_FRAME_ERR_EN
  , output logic     rx_frame_err_o
`endif
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic             sync1_q;
  logic             sync2_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             ready_q;
`ifdef UART_FRAME_ERR_EN
  logic             err_q;
`endif

  // Synchroniser resets to the idle line level so reset release cannot fake a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (idx_q == IDX_LAST) state_q <= RX_STOP;
            else                   idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
            end
`ifdef UART_FRAME_ERR_EN
            else begin
              err_q <= 1'b1;
            end
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data_o  = data_q;
  assign rx_ready_o = ready_q;
`ifdef UART_FRAME_ERR_EN
  assign rx_frame_err_o = err_q;
`endif

endmodule

// File: rtl/uart_txrx_top.sv
// Full-duplex 8N1 UART: inline transmitter FSM plus uart_rx; tx falls one edge after tx_start is sampled.
// tx_start is ignored while tx_busy (no queueing); UART_FRAME_ERR_EN adds the rx_frame_err port.
module uart_txrx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
`ifdef UART_FRAME_ERR_EN
  output logic       rx_frame_err,
`endif
  output logic       tx_busy
);

  localparam int               CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST     = 3'(DATA_BITS - 1);

  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_idx_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             tx_busy_q;

  // tx_q always carries the level of the bit currently on the line, so it is updated one
  // transition ahead of the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q      <= 1'b1;
          tx_busy_q <= 1'b0;
          tx_cnt_q  <= '0;
          tx_idx_q  <= '0;
          if (tx_start) begin
            tx_shift_q <= tx_data;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == IDX_LAST) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              tx_q       <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i          (clk),
    .rst_ni         (reset),
    .rx_i           (rx),
    .rx_data_o      (rx_data),
    .rx_ready_o     (rx_ready)
`ifdef UART_FRAME_ERR_EN
    , .rx_frame_err_o (rx_frame_err)
`endif
  );

endmodule

// File: tb/tb_uart_txrx_top.sv
// Directed + random bench for uart_txrx_top: loopback frames, back-to-back, glitch, framing error, mid-frame reset.
module tb_uart_txrx_top;

  localparam int CPB = 50_000_000 / 115200;
  localparam int H   = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
  int         n_ferr = 0;
`endif

  logic loop;
  logic ext_rx;
  assign rx_line = loop ? tx : ext_rx;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic [7:0]  got[$];
  int unsigned rdy_cyc[$];
  logic [7:0]  exp_q[$];

  uart_txrx_top dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_line),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx           (tx),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
`ifdef UART_FRAME_ERR_EN
    .rx_frame_err (rx_frame_err),
`endif
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_ready) begin
      got.push_back(rx_data);
      rdy_cyc.push_back(cyc);
    end
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err) n_ferr++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy_low(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 11 * CPB && !found; i++) begin
      @(negedge clk);
      if (!tx_busy) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  // Loopback frame with a one-cycle tx_start: checks latency, every line bit, end of busy, RX result.
  task automatic send_frame(input logic [7:0] b);
    logic [9:0]  line;
    int unsigned t_s;
    int          nrx;
    line = {1'b1, b, 1'b0};
    nrx  = got.size();
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = b;
    @(negedge clk);
    check("tx_before_accept", {tx, tx_busy}, 2'b10);
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = ~b;
    @(negedge clk);
    check("tx_latency", {tx, tx_busy}, 2'b01);
    t_s = cyc;
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? H : CPB) @(negedge clk);
      check("tx_line_bit", {tx, tx_busy}, {line[k], 1'b1});
    end
    repeat (CPB - H) @(negedge clk);
    check("tx_frame_end", {tx, tx_busy}, 2'b10);
    exp_q.push_back(b);
    check("rx_pulse_count", got.size(), nrx + 1);
    check("rx_byte", got[$], b);
    check("rx_latency", rdy_cyc[$], t_s + 3 + H + 9 * CPB);
  endtask

  task automatic drive_ext(input logic [7:0] b, input logic stop, output int unsigned t0);
    logic [9:0] line;
    line = {stop, b, 1'b0};
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      ext_rx = line[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    ext_rx = 1'b1;
    repeat (50) @(negedge clk);
  endtask

  initial begin
    int          nrx;
    int unsigned t0;
    logic [7:0]  rb;

    reset    = 1'b0;
    loop     = 1'b1;
    ext_rx   = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // Reset state held for 8 cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_state", {tx, tx_busy, rx_ready, rx_data}, {1'b1, 1'b0, 1'b0, 8'h00});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 8'h41
    send_frame(8'h41);

    // Back-to-back 00 then FF with tx_start held through the first frame
    nrx = got.size();
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk); #1;
    tx_data  = 8'hFF;
    @(negedge clk);
    check("b2b_first_busy", {tx, tx_busy}, 2'b01);
    wait_busy_low("b2b_first_done");
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("b2b_no_gap", {tx, tx_busy}, 2'b01);
    wait_busy_low("b2b_second_done");
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check("b2b_pulse_count", got.size(), nrx + 2);
    check("b2b_byte0", got[nrx], 8'h00);
    check("b2b_byte1", got[nrx+1], 8'hFF);

    // Random loopback bytes
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb);
    end

    // External line: 100-cycle low glitch must be rejected
    repeat (10) @(negedge clk);
    loop = 1'b0;
    nrx  = got.size();
    @(posedge clk); #1;
    ext_rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    ext_rx = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_no_ready", got.size(), nrx);

    // Good external frame proves the receiver is back in idle
    drive_ext(8'h3C, 1'b1, t0);
    exp_q.push_back(8'h3C);
    check("ext_pulse_count", got.size(), nrx + 1);
    check("ext_byte", got[$], 8'h3C);
    check("ext_latency", rdy_cyc[$], t0 + 3 + H + 9 * CPB);

    // Framing error: stop bit forced low
    nrx = got.size();
    drive_ext(8'hA5, 1'b0, t0);
    repeat (600) @(negedge clk);
    check("ferr_no_ready", got.size(), nrx);
    check("ferr_rx_data_held", rx_data, 8'h3C);
`ifdef UART_FRAME_ERR_EN
    check("ferr_pulse_count", n_ferr, 1);
`endif

    // Reset during data bit 3 of a loopback 8'h41 frame
    loop = 1'b1;
    nrx  = got.size();
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_data  = 8'h41;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("mid_busy", tx_busy, 1'b1);
    repeat (4 * CPB + H) @(negedge clk);
    check("mid_bit3_level", tx, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_reset_async", {tx, tx_busy}, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (800) @(negedge clk);
    check("mid_no_ready", got.size(), nrx);
    check("mid_rx_data_cleared", rx_data, 8'h00);
    send_frame(8'h41);

    // Whole-run scoreboard
    check("sb_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check("sb_byte", got[i], exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
